muldiv_unit: RTL

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a width-parametrised datapath. It complements the combinational single-cycle ALU: the decode stage routes M-extension ops here, and the core stalls on the valid/ready handshake until the result returns. The unit uses a radix-2 shift-add multiplier and a restoring divider sharing one accumulator, and is sequenced by a small FSM.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/div_restoring_step.sv | 22 ++
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the iterative M-extension unit:
// op encodings, the muldiv FSM state type and the MIN_INT helper.
package alu_pkg;

    localparam logic [4:0] OpAdd    = 5'b00000;
    localparam logic [4:0] OpSub    = 5'b00001;
    localparam logic [4:0] OpAnd    = 5'b00010;
    localparam logic [4:0] OpOr     = 5'b00011;
    localparam logic [4:0] OpXor    = 5'b00100;
    localparam logic [4:0] OpSll    = 5'b00101;
    localparam logic [4:0] OpSrl    = 5'b00110;
    localparam logic [4:0] OpSra    = 5'b00111;
    localparam logic [4:0] OpSlt    = 5'b01000;
    localparam logic [4:0] OpSltu   = 5'b01001;

    localparam logic [4:0] OpMul    = 5'b01010;
    localparam logic [4:0] OpMulh   = 5'b01011;
    localparam logic [4:0] OpMulhsu = 5'b01100;
    localparam logic [4:0] OpMulhu  = 5'b01101;
    localparam logic [4:0] OpDiv    = 5'b01110;
    localparam logic [4:0] OpDivu   = 5'b01111;
    localparam logic [4:0] OpRem    = 5'b10000;
    localparam logic [4:0] OpRemu   = 5'b10001;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} muldiv_state_e;

    localparam int unsigned MaxWidth = 64;

    // Most negative two's-complement value of a width-bit word; truncate at the call site.
    function automatic logic [MaxWidth-1:0] min_int(int unsigned width);
        return MaxWidth'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between the core and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    logic             illegal_op;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, div_by_zero, illegal_op
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, div_by_zero, illegal_op
    );
endinterface

// File: rtl/div_restoring_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when it fits.
module div_restoring_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial = {rem, dividend_bit};
        diff  = trial - {1'b0, divisor};
        q_bit = ~diff[WIDTH];
        // rem < divisor on entry, so the kept value always fits in WIDTH bits
        rem_next = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiplier and restoring divider
// share the hi/lo accumulator; signs are stripped at accept and restored in FIX.
module muldiv_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int unsigned      CntW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinInt = WIDTH'(min_int(WIDTH));

    muldiv_state_e      state_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q, opnd_q;
    logic               is_mul_q, sel_hi_q, neg_q;
    logic               in_ready_q, out_valid_q, dbz_q, ill_q;
    logic [WIDTH-1:0]   result_q;

    logic legal, op_mul, op_rem, op_hi, sgn_a, sgn_b;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        legal  = 1'b1;
        op_mul = 1'b0;
        op_rem = 1'b0;
        op_hi  = 1'b0;
        sgn_a  = 1'b0;
        sgn_b  = 1'b0;
        case (bus.op)
            OpMul:    begin op_mul = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            OpMulh:   begin op_mul = 1'b1; op_hi = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            OpMulhsu: begin op_mul = 1'b1; op_hi = 1'b1; sgn_a = 1'b1; end
            OpMulhu:  begin op_mul = 1'b1; op_hi = 1'b1; end
            OpDiv:    begin sgn_a = 1'b1; sgn_b = 1'b1; end
            OpDivu:   ;
            OpRem:    begin op_rem = 1'b1; op_hi = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
            OpRemu:   begin op_rem = 1'b1; op_hi = 1'b1; end
            default:  legal = 1'b0;
        endcase
        a_neg = sgn_a & bus.a[WIDTH-1];
        b_neg = sgn_b & bus.b[WIDTH-1];
        a_mag = a_neg ? -bus.a : bus.a;
        b_mag = b_neg ? -bus.b : bus.b;
    end

    logic             spec_hit, spec_dbz, spec_ill;
    logic [WIDTH-1:0] spec_result;

    always_comb begin
        spec_hit    = 1'b0;
        spec_dbz    = 1'b0;
        spec_ill    = 1'b0;
        spec_result = '0;
        if (!legal) begin
            spec_hit = 1'b1;
            spec_ill = 1'b1;
        end else if (!op_mul && bus.b == '0) begin
            spec_hit    = 1'b1;
            spec_dbz    = 1'b1;
            spec_result = op_rem ? bus.a : '1;
        end else if (!op_mul && sgn_a && bus.a == MinInt && bus.b == '1) begin
            spec_hit    = 1'b1;
            spec_result = op_rem ? '0 : MinInt;
        end
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;
    logic [WIDTH-1:0] step_hi, step_lo;

    div_restoring_step #(.WIDTH(WIDTH)) u_div_step (
        .rem          (hi_q),
        .dividend_bit (lo_q[WIDTH-1]),
        .divisor      (opnd_q),
        .rem_next     (div_rem),
        .q_bit        (div_q)
    );

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        if (is_mul_q) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            step_hi = div_rem;
            step_lo = {lo_q[WIDTH-2:0], div_q};
        end
    end

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   div_val, fix_result;

    always_comb begin
        // Product sign is applied to the full double-width value so the high half borrows correctly
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        div_val  = sel_hi_q ? hi_q : lo_q;
        if (is_mul_q) begin
            fix_result = sel_hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        end else begin
            fix_result = neg_q ? -div_val : div_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            is_mul_q    <= 1'b0;
            sel_hi_q    <= 1'b0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        in_ready_q <= 1'b0;
                        if (spec_hit) begin
                            state_q  <= StDone;
                            result_q <= spec_result;
                            dbz_q    <= spec_dbz;
                            ill_q    <= spec_ill;
                        end else begin
                            state_q  <= StCalc;
                            cnt_q    <= CntW'(WIDTH);
                            is_mul_q <= op_mul;
                            sel_hi_q <= op_hi;
                            neg_q    <= op_rem ? a_neg : (a_neg ^ b_neg);
                            hi_q     <= '0;
                            lo_q     <= op_mul ? b_mag : a_mag;
                            opnd_q   <= op_mul ? a_mag : b_mag;
                        end
                    end
                end
                StCalc: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) state_q <= StFix;
                end
                StFix: begin
                    result_q    <= fix_result;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    // Special cases enter DONE with the result already set; valid follows one edge later
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        result_q    <= '0;
                        dbz_q       <= 1'b0;
                        ill_q       <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.illegal_op  = ill_q;
endmodule
